// File: rtl/clock_domain_marshal_pkg.sv
// Types and constants shared by the clock-domain marshalling blocks.
package clock_domain_marshal_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } hs_state_t;

  localparam int unsigned MIN_SYNC_STAGES = 2;

endpackage

// File: rtl/clock_domain_handshake_sender_sync_chain.sv
// Single-bit synchroniser chain; asynchronous active-low reset to 0.
module sync_chain
  import clock_domain_marshal_pkg::*;
#(
  parameter int unsigned STAGES = MIN_SYNC_STAGES
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  // Never build a chain shorter than the metastability minimum.
  localparam int unsigned DEPTH = (STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : STAGES;

  logic [DEPTH-1:0] chain;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      chain <= '0;
    end else begin
      chain <= {chain[DEPTH-2:0], d};
    end
  end

  assign q = chain[DEPTH-1];

endmodule

// File: rtl/clock_domain_handshake_sender.sv
// Source half of a toggle req/ack crossing: FIFO-buffered words launched one at a time.
module clock_domain_handshake_sender
  import clock_domain_marshal_pkg::*;
#(
  parameter int unsigned BUS_WIDTH   = 32,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          inValid,
  input  logic [BUS_WIDTH-1:0]          inData,
  output logic                          inReady,
  output logic [BUS_WIDTH-1:0]          reqData,
  output logic                          reqToggle,
  input  logic                          ackToggle,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   pending,
  output logic                          protocolError
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

  hs_state_t            state;
  logic [BUS_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     head;
  logic [PTR_W-1:0]     tail;
  logic [CNT_W-1:0]     count;
  logic                 ack_sync;
  logic                 ack_sync_prev;
  logic                 ack_seen;
  logic                 push;
  logic                 pop;

  sync_chain #(
    .STAGES(SYNC_STAGES)
  ) u_ack_sync (
    .clock (clock),
    .reset (reset),
    .d     (ackToggle),
    .q     (ack_sync)
  );

  assign ack_seen = (ack_sync == reqToggle);
  assign inReady  = (count != FULL_COUNT);
  assign push     = inValid && inReady;
  // Launch uses the registered count, so a word pushed this cycle is not yet poppable.
  assign pop      = (count != '0) && ((state == IDLE) || ack_seen);
  assign pending  = count;

  always_ff @(posedge clock) begin
    if (push) begin
      mem[tail] <= inData;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        tail <= tail + PTR_ONE;
      end
      if (pop) begin
        head <= head + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      busy          <= 1'b0;
      reqData       <= '0;
      reqToggle     <= 1'b0;
      ack_sync_prev <= 1'b0;
      protocolError <= 1'b0;
    end else begin
      ack_sync_prev <= ack_sync;
      // An ack edge with nothing outstanding means the two sides are out of step.
      if ((state == IDLE) && (ack_sync != ack_sync_prev)) begin
        protocolError <= 1'b1;
      end
      if (pop) begin
        reqData   <= mem[head];
        reqToggle <= ~reqToggle;
        state     <= WAIT_ACK;
        busy      <= 1'b1;
      end else if ((state == WAIT_ACK) && ack_seen) begin
        state <= IDLE;
        busy  <= 1'b0;
      end
    end
  end

endmodule
